// File: rtl/lcd_arb_pkg.sv
// Shared types and helpers for the LCD screen arbiter.
package lcd_arb_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_RUN,
        S_PENDING,
        S_RESTART,
        S_BLANK
    } arb_state_e;

    localparam logic [15:0] BLACK_PIXEL = 16'h0000;
    localparam int unsigned MAX_SCREENS = 8;

    // Index of the highest set bit; 0 when no bit is set.
    function automatic int unsigned highest_set(input logic [MAX_SCREENS-1:0] v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < MAX_SCREENS; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_screen_arbiter_if.sv
// Bus between the pixel generators / LCD controller and the screen arbiter.
interface lcd_screen_arbiter_if #(
    parameter int unsigned NUM_SCREENS = 4,
    parameter int unsigned PIX_W       = 16
);
    localparam int unsigned IDX_W = $clog2(NUM_SCREENS);

    logic [NUM_SCREENS-1:0]       req;
    logic [NUM_SCREENS*PIX_W-1:0] pix_in;
    logic [NUM_SCREENS-1:0]       avail_in;
    logic                         frame_done;
    logic [PIX_W-1:0]             pix_out;
    logic                         p_available;
    logic                         rst_corner;
    logic [IDX_W-1:0]             active_idx;
    logic                         switch_pending;

    modport master (
        output req, pix_in, avail_in, frame_done,
        input  pix_out, p_available, rst_corner, active_idx, switch_pending
    );

    modport slave (
        input  req, pix_in, avail_in, frame_done,
        output pix_out, p_available, rst_corner, active_idx, switch_pending
    );

endinterface

// File: rtl/lcd_arb_prio_enc.sv
// Priority encoder: index of the highest asserted request plus a valid flag.
module lcd_arb_prio_enc
    import lcd_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [MAX_SCREENS-1:0] req_ext;

    assign req_ext = MAX_SCREENS'(req_i);
    assign idx_o   = IDX_W'(highest_set(req_ext));
    assign valid_o = |req_i;

endmodule

// File: rtl/lcd_screen_arbiter.sv
// Frame-synchronous screen selector with dwell time and corner-restart pulse.
// Optional LCD_ARB_BLANK_EN inserts one black frame after every screen switch.
module lcd_screen_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int unsigned NUM_SCREENS      = 4,
    parameter int unsigned PIX_W            = 16,
    parameter int unsigned DEFAULT_SCREEN   = 1,
    parameter int unsigned MIN_DWELL_FRAMES = 2,
    parameter int unsigned DWELL_W          = 4
) (
    input logic                 clk,
    input logic                 rst,
    lcd_screen_arbiter_if.slave arb_io
);

    localparam int unsigned IDX_W = $clog2(NUM_SCREENS);
    localparam logic [IDX_W-1:0]   DefaultIdx = IDX_W'(DEFAULT_SCREEN);
    localparam logic [DWELL_W-1:0] MinDwell   = DWELL_W'(MIN_DWELL_FRAMES);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   active_q, active_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_inc;
    logic [IDX_W-1:0]   enc_idx, target;
    logic               enc_valid;

    logic [PIX_W-1:0]   pix_q, pix_d, pix_sel;
    logic               avail_q, avail_d, avail_sel;
    logic               rst_corner, switch_pending;

    lcd_arb_prio_enc #(
        .N     (NUM_SCREENS),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req_i   (arb_io.req),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign target    = enc_valid ? enc_idx : DefaultIdx;
    assign dwell_inc = (dwell_q < MinDwell) ? dwell_q + 1'b1 : dwell_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_INIT;
            active_q <= DefaultIdx;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            dwell_q  <= dwell_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        dwell_d  = dwell_q;
        unique case (state_q)
            S_INIT: state_d = S_RUN;
            S_RUN: begin
                if (arb_io.frame_done) dwell_d = dwell_inc;
                if (target != active_q) state_d = S_PENDING;
            end
            S_PENDING: begin
                if (target == active_q) begin
                    state_d = S_RUN;
                end else if (arb_io.frame_done && (dwell_q >= MinDwell)) begin
                    // Target is sampled here, so intermediate requests never show.
                    active_d = target;
                    dwell_d  = '0;
                    state_d  = S_RESTART;
                end else if (arb_io.frame_done) begin
                    dwell_d = dwell_inc;
                end
            end
`ifdef LCD_ARB_BLANK_EN
            S_RESTART: state_d = S_BLANK;
            // S_INIT re-issues the corner pulse, then hands over to S_RUN.
            S_BLANK: if (arb_io.frame_done) state_d = S_INIT;
`else
            S_RESTART: state_d = S_RUN;
            S_BLANK: state_d = S_RUN;
`endif
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        pix_sel   = '0;
        avail_sel = 1'b0;
        for (int i = 0; i < NUM_SCREENS; i++) begin
            if (active_q == IDX_W'(i)) begin
                pix_sel   = arb_io.pix_in[i*PIX_W +: PIX_W];
                avail_sel = arb_io.avail_in[i];
            end
        end
    end

    always_comb begin
        rst_corner     = !rst && ((state_q == S_INIT) || (state_q == S_RESTART));
        switch_pending = !rst && (state_q == S_PENDING);
        pix_d          = pix_sel;
        avail_d        = avail_sel;
`ifdef LCD_ARB_BLANK_EN
        if (state_q == S_BLANK) begin
            pix_d   = PIX_W'(BLACK_PIXEL);
            avail_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q   <= '0;
            avail_q <= 1'b0;
        end else begin
            pix_q   <= pix_d;
            avail_q <= avail_d;
        end
    end

    assign arb_io.pix_out        = pix_q;
    assign arb_io.p_available    = avail_q;
    assign arb_io.rst_corner     = rst_corner;
    assign arb_io.active_idx     = active_q;
    assign arb_io.switch_pending = switch_pending;

endmodule

// File: tb/tb_lcd_screen_arbiter.sv
// Directed self-checking bench for lcd_screen_arbiter (default parameters).
module tb_lcd_screen_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic seen2 = 1'b0;
    logic corner_twice = 1'b0;
    logic prev_corner = 1'b0;

    lcd_screen_arbiter_if #(.NUM_SCREENS(4), .PIX_W(16)) arb_if ();

    lcd_screen_arbiter #(
        .NUM_SCREENS      (4),
        .PIX_W            (16),
        .DEFAULT_SCREEN   (1),
        .MIN_DWELL_FRAMES (2),
        .DWELL_W          (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_io (arb_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (arb_if.active_idx == 2'd2) seen2 = 1'b1;
            if (arb_if.rst_corner && prev_corner) corner_twice = 1'b1;
            prev_corner = arb_if.rst_corner;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_frame();
        arb_if.frame_done = 1'b1;
        tick();
        arb_if.frame_done = 1'b0;
    endtask

    // Called right after the committing edge; ends back in S_RUN.
    task automatic after_commit(input logic [15:0] exp_pix, input logic exp_av);
`ifdef LCD_ARB_BLANK_EN
        tick();
        chk("blank_enter_corner", 32'(arb_if.rst_corner), 32'd0);
        tick();
        chk("blank_pix", 32'(arb_if.pix_out), 32'h0000);
        chk("blank_avail", 32'(arb_if.p_available), 32'd1);
        idle(4);
        pulse_frame();
        chk("blank_exit_corner", 32'(arb_if.rst_corner), 32'd1);
        tick();
        chk("post_blank_corner", 32'(arb_if.rst_corner), 32'd0);
        chk("post_blank_pix", 32'(arb_if.pix_out), 32'(exp_pix));
        chk("post_blank_avail", 32'(arb_if.p_available), 32'(exp_av));
`else
        tick();
        chk("post_commit_corner", 32'(arb_if.rst_corner), 32'd0);
        chk("post_commit_pix", 32'(arb_if.pix_out), 32'(exp_pix));
        chk("post_commit_avail", 32'(arb_if.p_available), 32'(exp_av));
`endif
    endtask

    initial begin
        rst               = 1'b1;
        arb_if.req        = 4'b0000;
        arb_if.frame_done = 1'b0;
        arb_if.avail_in   = 4'b1010;
        arb_if.pix_in     = {16'hF800, 16'h2222, 16'h1111, 16'h0A0A};

        // Reset, including a frame_done that must be swallowed by reset.
        tick();
        tick();
        arb_if.frame_done = 1'b1;
        tick();
        chk("rst_active_idx", 32'(arb_if.active_idx), 32'd1);
        chk("rst_corner", 32'(arb_if.rst_corner), 32'd0);
        chk("rst_pix", 32'(arb_if.pix_out), 32'd0);
        chk("rst_avail", 32'(arb_if.p_available), 32'd0);
        chk("rst_pending", 32'(arb_if.switch_pending), 32'd0);

        rst = 1'b0;
        arb_if.frame_done = 1'b0;
        #1;
        chk("init_corner", 32'(arb_if.rst_corner), 32'd1);
        chk("init_pix", 32'(arb_if.pix_out), 32'd0);
        tick();
        chk("run_corner", 32'(arb_if.rst_corner), 32'd0);
        chk("run_pix_scr1", 32'(arb_if.pix_out), 32'h1111);
        chk("run_avail_scr1", 32'(arb_if.p_available), 32'd1);

        // One frame in S_RUN: dwell = 1.
        idle(5);
        pulse_frame();

        // Request raised then dropped before any frame_done.
        arb_if.req = 4'b0001;
        tick();
        chk("drop_pending", 32'(arb_if.switch_pending), 32'd1);
        arb_if.req = 4'b0000;
        tick();
        chk("drop_unpending", 32'(arb_if.switch_pending), 32'd0);
        chk("drop_active", 32'(arb_if.active_idx), 32'd1);
        chk("drop_no_corner", 32'(arb_if.rst_corner), 32'd0);

        // Request 2, then 3 before commit: commits straight to 3.
        arb_if.req = 4'b0100;
        tick();
        chk("req2_pending", 32'(arb_if.switch_pending), 32'd1);
        idle(10);
        pulse_frame();
        chk("req2_hold_active", 32'(arb_if.active_idx), 32'd1);
        chk("req2_hold_pending", 32'(arb_if.switch_pending), 32'd1);
        arb_if.req = 4'b1000;
        tick();
        chk("req3_pending", 32'(arb_if.switch_pending), 32'd1);
        idle(10);
        pulse_frame();
        chk("commit3_active", 32'(arb_if.active_idx), 32'd3);
        chk("commit3_corner", 32'(arb_if.rst_corner), 32'd1);
        chk("commit3_unpending", 32'(arb_if.switch_pending), 32'd0);
        chk("commit3_old_pix", 32'(arb_if.pix_out), 32'h1111);
        after_commit(16'hF800, 1'b1);

        // p_available follows screen 3 only, with one cycle latency.
        arb_if.avail_in = 4'b0010;
        chk("avail_latency", 32'(arb_if.p_available), 32'd1);
        tick();
        chk("avail3_low", 32'(arb_if.p_available), 32'd0);
        arb_if.avail_in = 4'b1000;
        tick();
        chk("avail3_high", 32'(arb_if.p_available), 32'd1);
        arb_if.pix_in[63:48] = 16'h07E0;
        tick();
        chk("pix3_follow", 32'(arb_if.pix_out), 32'h07E0);
        arb_if.pix_in[63:48] = 16'hF800;

        // Back to default screen: dwell restarted at 0, needs three frames.
        arb_if.req = 4'b0000;
        tick();
        chk("dflt_pending", 32'(arb_if.switch_pending), 32'd1);
        pulse_frame();
        pulse_frame();
        chk("dflt_dwell_hold", 32'(arb_if.active_idx), 32'd3);
        pulse_frame();
        chk("dflt_commit", 32'(arb_if.active_idx), 32'd1);
        chk("dflt_corner", 32'(arb_if.rst_corner), 32'd1);
        after_commit(16'h1111, 1'b0);

`ifndef LCD_ARB_BLANK_EN
        // frame_done held through S_RESTART must not count toward dwell.
        arb_if.req = 4'b1000;
        tick();
        arb_if.frame_done = 1'b1;
        idle(3);
        chk("hold_fd_commit", 32'(arb_if.active_idx), 32'd3);
        chk("hold_fd_corner", 32'(arb_if.rst_corner), 32'd1);
        tick();
        arb_if.frame_done = 1'b0;
        chk("hold_fd_single_corner", 32'(arb_if.rst_corner), 32'd0);
        arb_if.req = 4'b0000;
        tick();
        pulse_frame();
        pulse_frame();
        chk("restart_fd_ignored", 32'(arb_if.active_idx), 32'd3);
        pulse_frame();
        chk("restart_fd_commit", 32'(arb_if.active_idx), 32'd1);
        tick();
`endif

        chk("never_screen2", 32'(seen2), 32'd0);
        chk("corner_single", 32'(corner_twice), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
